// File: rtl/constants_pkg.sv
// rtl/constants_pkg.sv - shared datapath widths and the writeback entry type
package constants;

    localparam int WORD_SIZE  = 19;
    localparam int REG_ADDR_W = 3;

    typedef struct packed {
        logic [WORD_SIZE-1:0]  data;
        logic [REG_ADDR_W-1:0] rd;
        logic                  set_flags;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - ALU result buffer; age-ordered entry view only with ALU_WB_FORWARD_EN
module wb_fifo
    import constants::wb_entry_t;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  wb_entry_t        push_entry,
    input  logic             pop,
    output wb_entry_t        head,
    output logic [CNT_W-1:0] count
`ifdef ALU_WB_FORWARD_EN
    ,
    output logic [DEPTH-1:0] age_valid,
    output wb_entry_t        age_entry [DEPTH]
`endif
);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // Depth need not be a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wrap_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= wrap_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

`ifdef ALU_WB_FORWARD_EN
    // Index 0 is the oldest entry (the head), higher indices are younger.
    function automatic logic [PTR_W-1:0] slot_of(input int age);
        return PTR_W'((int'(rd_ptr) + age) % DEPTH);
    endfunction

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            age_entry[k] = mem[slot_of(k)];
            age_valid[k] = (k < int'(count));
        end
    end
`endif

endmodule

// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - writeback stage: load-priority arbitration, write registers, Z/N flags; forwarding with ALU_WB_FORWARD_EN
module alu_writeback
    import constants::wb_entry_t;
#(
    parameter int WORD_SIZE  = constants::WORD_SIZE,
    parameter int REG_ADDR_W = constants::REG_ADDR_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [WORD_SIZE-1:0]  alu_result,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic                  alu_set_flags,
    input  logic                  ld_valid,
    input  logic [WORD_SIZE-1:0]  ld_data,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [WORD_SIZE-1:0]  rf_wdata,
    output logic                  flag_z,
    output logic                  flag_n,
    output logic                  pending
`ifdef ALU_WB_FORWARD_EN
    ,
    input  logic [REG_ADDR_W-1:0] fwd_raddr,
    output logic                  fwd_hit,
    output logic [WORD_SIZE-1:0]  fwd_data
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    wb_entry_t        push_entry;
    wb_entry_t        head;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

`ifdef ALU_WB_FORWARD_EN
    logic [FIFO_DEPTH-1:0] age_valid;
    wb_entry_t             age_entry [FIFO_DEPTH];
`endif

    // Ready looks only at registered occupancy, keeping ld_valid off the ready path.
    assign alu_ready  = !rst && (count < CNT_W'(FIFO_DEPTH));
    assign push       = alu_valid && alu_ready;
    assign pop        = !ld_valid && (count != '0);
    assign push_entry = '{data: alu_result, rd: alu_rd, set_flags: alu_set_flags};
    assign pending    = (count != '0) || rf_we;

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
`ifdef ALU_WB_FORWARD_EN
        .age_valid  (age_valid),
        .age_entry  (age_entry),
`endif
        .count      (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            flag_z   <= 1'b0;
            flag_n   <= 1'b0;
        end else if (ld_valid) begin
            rf_we    <= 1'b1;
            rf_waddr <= ld_rd;
            rf_wdata <= ld_data;
        end else if (pop) begin
            rf_we    <= 1'b1;
            rf_waddr <= head.rd;
            rf_wdata <= head.data;
            if (head.set_flags) begin
                flag_z <= (head.data == '0);
                flag_n <= head.data[WORD_SIZE-1];
            end
        end else begin
            rf_we <= 1'b0;
        end
    end

`ifdef ALU_WB_FORWARD_EN
    // Later (younger) matches override earlier ones; the registered write is the fallback.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (rf_we && (rf_waddr == fwd_raddr)) begin
            fwd_hit  = 1'b1;
            fwd_data = rf_wdata;
        end
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            if (age_valid[k] && (age_entry[k].rd == fwd_raddr)) begin
                fwd_hit  = 1'b1;
                fwd_data = age_entry[k].data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// tb/tb_alu_writeback.sv - randomized bench for alu_writeback against a queue-based reference model
module tb_alu_writeback;

    localparam int W  = 19;
    localparam int AW = 3;
    localparam int D  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          alu_valid = 1'b0;
    logic          alu_ready;
    logic [W-1:0]  alu_result = '0;
    logic [AW-1:0] alu_rd = '0;
    logic          alu_set_flags = 1'b0;
    logic          ld_valid = 1'b0;
    logic [W-1:0]  ld_data = '0;
    logic [AW-1:0] ld_rd = '0;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [W-1:0]  rf_wdata;
    logic          flag_z;
    logic          flag_n;
    logic          pending;
`ifdef ALU_WB_FORWARD_EN
    logic [AW-1:0] fwd_raddr = '0;
    logic          fwd_hit;
    logic [W-1:0]  fwd_data;
`endif

    always #5 clk = ~clk;

    alu_writeback #(.WORD_SIZE(W), .REG_ADDR_W(AW), .FIFO_DEPTH(D)) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_result    (alu_result),
        .alu_rd        (alu_rd),
        .alu_set_flags (alu_set_flags),
        .ld_valid      (ld_valid),
        .ld_data       (ld_data),
        .ld_rd         (ld_rd),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .flag_z        (flag_z),
        .flag_n        (flag_n),
`ifdef ALU_WB_FORWARD_EN
        .fwd_raddr     (fwd_raddr),
        .fwd_hit       (fwd_hit),
        .fwd_data      (fwd_data),
`endif
        .pending       (pending)
    );

    typedef struct {
        logic [W-1:0]  data;
        logic [AW-1:0] rd;
        bit            sf;
    } ment_t;

    ment_t         q[$];
    bit            m_we;
    logic [AW-1:0] m_addr;
    logic [W-1:0]  m_data;
    bit            m_z;
    bit            m_n;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_we = 0; m_addr = '0; m_data = '0; m_z = 0; m_n = 0;
    endtask

    task automatic compare_outputs();
        check("alu_ready", 32'(alu_ready), 32'(q.size() < D));
        check("rf_we", 32'(rf_we), 32'(m_we));
        if (m_we) begin
            check("rf_waddr", 32'(rf_waddr), 32'(m_addr));
            check("rf_wdata", 32'(rf_wdata), 32'(m_data));
        end
        check("flag_z", 32'(flag_z), 32'(m_z));
        check("flag_n", 32'(flag_n), 32'(m_n));
        check("pending", 32'(pending), 32'(q.size() != 0 || m_we));
`ifdef ALU_WB_FORWARD_EN
        begin
            bit           e_hit = 0;
            logic [W-1:0] e_data = '0;
            fwd_raddr = AW'($urandom);
            #1;
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].rd == fwd_raddr) begin
                    e_hit = 1; e_data = q[i].data;
                    break;
                end
            end
            if (!e_hit && m_we && m_addr == fwd_raddr) begin
                e_hit = 1; e_data = m_data;
            end
            check("fwd_hit", 32'(fwd_hit), 32'(e_hit));
            check("fwd_data", 32'(fwd_data), 32'(e_data));
        end
`endif
    endtask

    // Called at a falling edge: drive inputs, advance the model across the next rising edge, then compare.
    task automatic step(input bit av, input logic [W-1:0] ar, input logic [AW-1:0] ard, input bit asf,
                        input bit lv, input logic [W-1:0] ldd, input logic [AW-1:0] lrd);
        bit    acc;
        ment_t e;
        alu_valid = av; alu_result = ar; alu_rd = ard; alu_set_flags = asf;
        ld_valid = lv; ld_data = ldd; ld_rd = lrd;
        acc = av && (q.size() < D);
        if (lv) begin
            m_we = 1; m_addr = lrd; m_data = ldd;
        end else if (q.size() > 0) begin
            e = q.pop_front();
            m_we = 1; m_addr = e.rd; m_data = e.data;
            if (e.sf) begin
                m_z = (e.data == 0);
                m_n = e.data[W-1];
            end
        end else begin
            m_we = 0;
        end
        if (acc) q.push_back('{data: ar, rd: ard, sf: asf});
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic idle();
        step(0, '0, '0, 0, 0, '0, '0);
    endtask

    initial begin
        model_reset();
        #1;
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_alu_ready", 32'(alu_ready), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_rf_wdata", 32'(rf_wdata), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        compare_outputs();

        // basic write: visible two cycles after acceptance
        step(1, 19'h00005, 3'd3, 1, 0, '0, '0);
        check("basic_we_early", 32'(rf_we), 32'd0);
        idle();
        check("basic_we", 32'(rf_we), 32'd1);
        check("basic_addr", 32'(rf_waddr), 32'd3);
        check("basic_data", 32'(rf_wdata), 32'h5);
        check("basic_z", 32'(flag_z), 32'd0);
        check("basic_n", 32'(flag_n), 32'd0);
        idle();

        // flags
        step(1, 19'h00000, 3'd1, 1, 0, '0, '0); idle();
        check("zero_z", 32'(flag_z), 32'd1);
        step(1, 19'h40000, 3'd1, 0, 0, '0, '0); idle();
        check("noflag_z", 32'(flag_z), 32'd1);
        check("noflag_n", 32'(flag_n), 32'd0);
        step(1, 19'h40000, 3'd1, 1, 0, '0, '0); idle();
        check("neg_n", 32'(flag_n), 32'd1);
        check("neg_z", 32'(flag_z), 32'd0);
        idle();

        // load priority with the FIFO filling behind it
        step(1, 19'h00111, 3'd1, 0, 1, 19'h000AA, 3'd4);
        step(1, 19'h00222, 3'd2, 0, 1, 19'h000BB, 3'd5);
        check("ldprio_full_ready", 32'(alu_ready), 32'd0);
        step(1, 19'h00333, 3'd3, 0, 1, 19'h000CC, 3'd6);
        check("ldprio_ld3", 32'(rf_wdata), 32'hCC);
        idle();
        check("ldprio_alu1", 32'(rf_wdata), 32'h111);
        idle();
        check("ldprio_alu2", 32'(rf_wdata), 32'h222);
        idle(); idle();

        // back-to-back stream
        for (int i = 0; i < 10; i++) step(1, W'(32'h100 + i), AW'(i), 0, 0, '0, '0);
        idle(); idle(); idle();

`ifdef ALU_WB_FORWARD_EN
        step(1, 19'h00011, 3'd2, 0, 1, 19'h00077, 3'd7);
        step(1, 19'h00022, 3'd2, 0, 1, 19'h00078, 3'd7);
        fwd_raddr = 3'd2; #1;
        check("fwd_young_hit", 32'(fwd_hit), 32'd1);
        check("fwd_young_data", 32'(fwd_data), 32'h22);
        fwd_raddr = 3'd5; #1;
        check("fwd_miss_hit", 32'(fwd_hit), 32'd0);
        check("fwd_miss_data", 32'(fwd_data), 32'd0);
        fwd_raddr = 3'd7; #1;
        check("fwd_reg_data", 32'(fwd_data), 32'h78);
        idle(); idle(); idle();
`endif

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] d;
            d = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
            step(bit'($urandom_range(0, 1)), d, AW'($urandom), bit'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), W'($urandom), AW'($urandom));
        end

        // reset with the FIFO full and a write registered
        step(1, 19'h7FFFF, 3'd6, 1, 1, 19'h12345, 3'd1);
        step(1, 19'h7FFFF, 3'd6, 1, 1, 19'h12346, 3'd2);
        check("pre_rst_ready", 32'(alu_ready), 32'd0);
        check("pre_rst_we", 32'(rf_we), 32'd1);
        alu_valid = 0; ld_valid = 0;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_we", 32'(rf_we), 32'd0);
        check("mid_rst_waddr", 32'(rf_waddr), 32'd0);
        check("mid_rst_wdata", 32'(rf_wdata), 32'd0);
        check("mid_rst_flags", 32'({flag_z, flag_n}), 32'd0);
        check("mid_rst_pending", 32'(pending), 32'd0);
        check("mid_rst_ready", 32'(alu_ready), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(alu_ready), 32'd1);
        idle(); idle(); idle();
        check("post_rst_pending", 32'(pending), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
